// File: rtl/alsu_cmd_ctrl.sv
// Command-side ALSU controller: drives each accepted command onto the ALSU pins for one cycle,
// then captures the result after the fixed ALSU latency into a credit-protected response FIFO.
module alsu_cmd_ctrl #(
  parameter int ALSU_LAT = 2,  // >= 1
  parameter int DEPTH    = 4   // >= 1; full throughput needs >= ALSU_LAT+2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  output logic [2:0]  A,
  output logic [2:0]  B,
  output logic [2:0]  opcode,
  output logic        cin,
  output logic        serial_in,
  output logic        direction,
  output logic        red_op_A,
  output logic        red_op_B,
  output logic        bypass_A,
  output logic        bypass_B,
  input  logic [5:0]  alsu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  rsp_data,
  output logic        rsp_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1) + 1;

  logic              accept;
  logic              push;
  logic              pop;
  logic              cmd_err;
  logic [2:0]        cmd_op;
  logic [15:0]       drive_q;
  logic [ALSU_LAT:0] pipe_vld;
  logic [ALSU_LAT:0] pipe_err;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credits_used;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [5:0]        mem_data [DEPTH];
  logic              mem_err  [DEPTH];

  // Error rule mirrors the ALSU's invalid-case definition; bypass does not mask it.
  assign cmd_op  = cmd_data[8:6];
  assign cmd_err = (cmd_op[2:1] == 2'b11) |
                   ((cmd_op[2:1] != 2'b00) & (cmd_data[12] | cmd_data[13]));

  // Credits cover both in-flight and buffered results, so the FIFO can never overflow.
  assign credits_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign cmd_ready    = !rst && (credits_used < (CW+1)'(DEPTH));

  assign accept    = cmd_valid & cmd_ready;
  assign push      = pipe_vld[ALSU_LAT];
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid & rsp_ready;

  assign A         = drive_q[2:0];
  assign B         = drive_q[5:3];
  assign opcode    = drive_q[8:6];
  assign cin       = drive_q[9];
  assign serial_in = drive_q[10];
  assign direction = drive_q[11];
  assign red_op_A  = drive_q[12];
  assign red_op_B  = drive_q[13];
  assign bypass_A  = drive_q[14];
  assign bypass_B  = drive_q[15];

  // All-zero idle vector is an AND of 0,0, which forces the ALSU output back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drive_q <= '0;
    end else if (accept) begin
      drive_q <= cmd_data;
    end else begin
      drive_q <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_err <= '0;
    end else begin
      pipe_vld <= {pipe_vld[ALSU_LAT-1:0], accept};
      pipe_err <= {pipe_err[ALSU_LAT-1:0], accept & cmd_err};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({accept, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= alsu_out;
      mem_err[wr_ptr]  <= pipe_err[ALSU_LAT];
    end
  end

  // Head is masked while empty so the response outputs read 0 out of reset.
  assign rsp_data = rsp_valid ? mem_data[rd_ptr] : '0;
  assign rsp_err  = rsp_valid ? mem_err[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_alsu_cmd_ctrl.sv
// Bench for alsu_cmd_ctrl: a behavioural ALSU drives alsu_out, and a response queue built
// from the command stream predicts handshake timing, order and result values.
module tb_alsu_cmd_ctrl;

  localparam int DEPTH = 4;
  localparam int LAT_RSP = 3;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;
  logic [2:0]  a_pin, b_pin, op_pin;
  logic        cin_pin, si_pin, dir_pin, ra_pin, rb_pin, ba_pin, bb_pin;
  logic [5:0]  alsu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [5:0]  rsp_data;
  logic        rsp_err;
  logic [15:0] pins;

  alsu_cmd_ctrl #(.ALSU_LAT(2), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .A(a_pin), .B(b_pin), .opcode(op_pin), .cin(cin_pin), .serial_in(si_pin),
    .direction(dir_pin), .red_op_A(ra_pin), .red_op_B(rb_pin),
    .bypass_A(ba_pin), .bypass_B(bb_pin),
    .alsu_out(alsu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  assign pins = {bb_pin, ba_pin, rb_pin, ra_pin, dir_pin, si_pin, cin_pin, op_pin, b_pin, a_pin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic err_fn(input logic [15:0] c);
    int op;
    op = int'(c[8:6]);
    return (op == 6) || (op == 7) || ((op > 1) && (c[12] || c[13]));
  endfunction

  function automatic logic [5:0] alsu_fn(input logic [15:0] c, input logic [5:0] prev);
    logic [2:0] a, b;
    a = c[2:0];
    b = c[5:3];
    if (c[14]) return {3'b000, a};
    if (c[15]) return {3'b000, b};
    if (err_fn(c)) return 6'd0;
    case (c[8:6])
      3'd0: return c[12] ? {5'd0, &a} : c[13] ? {5'd0, &b} : {3'd0, a & b};
      3'd1: return c[12] ? {5'd0, ^a} : c[13] ? {5'd0, ^b} : {3'd0, a ^ b};
      3'd2: return 6'(int'(a) + int'(b) + int'(c[9]));
      3'd3: return 6'(int'(a) * int'(b));
      3'd4: return c[11] ? {prev[4:0], c[10]} : {c[10], prev[5:1]};
      default: return c[11] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
    endcase
  endfunction

  function automatic logic [15:0] mk(input int a, input int b, input int op, input int cin,
                                     input int si, input int dir, input int ra, input int rb,
                                     input int ba, input int bb);
    logic [15:0] v;
    v = '0;
    v[2:0] = a[2:0];  v[5:3] = b[2:0];  v[8:6] = op[2:0];
    v[9] = cin[0];    v[10] = si[0];    v[11] = dir[0];
    v[12] = ra[0];    v[13] = rb[0];    v[14] = ba[0];    v[15] = bb[0];
    return v;
  endfunction

  // ALSU environment: input register then output register, shift/rotate on its own result.
  logic [15:0] alsu_in_r;
  logic [5:0]  alsu_out_r;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alsu_in_r  <= '0;
      alsu_out_r <= '0;
    end else begin
      alsu_in_r  <= pins;
      alsu_out_r <= alsu_fn(alsu_in_r, alsu_out_r);
    end
  end
  assign alsu_out = alsu_out_r;

  typedef struct { logic [5:0] data; logic err; int due; } rsp_t;
  rsp_t q[$];
  int total, bad, cyc, last_acc;
  logic [5:0]  last_res;
  logic        obs_ready, obs_valid, obs_err, exp_ready, exp_valid, exp_err, did_acc, did_pop;
  logic [5:0]  obs_data, exp_data;
  logic [15:0] obs_pins;

  // One clock: drive at the falling edge, sample, then advance the reference at the rising edge.
  task automatic cycle(input logic v, input logic [15:0] d, input logic rr);
    rsp_t e;
    logic [5:0] prev;
    cmd_valid = v; cmd_data = d; rsp_ready = rr;
    #1;
    obs_ready = cmd_ready; obs_valid = rsp_valid; obs_data = rsp_data;
    obs_err = rsp_err; obs_pins = pins;
    exp_ready = (q.size() < DEPTH) && !rst;
    exp_valid = 1'b0; exp_data = '0; exp_err = 1'b0;
    if (q.size() > 0) begin
      exp_valid = (q[0].due <= cyc);
      exp_data  = q[0].data;
      exp_err   = q[0].err;
    end
    did_acc = v && obs_ready;
    did_pop = obs_valid && rr;
    @(posedge clk);
    cyc++;
    if (did_pop && q.size() > 0) void'(q.pop_front());
    if (did_acc) begin
      prev   = (last_acc == cyc - 1) ? last_res : 6'd0;
      e.data = alsu_fn(d, prev);
      e.err  = err_fn(d);
      e.due  = cyc + LAT_RSP;
      q.push_back(e);
      last_acc = cyc;
      last_res = e.data;
    end
    @(negedge clk);
  endtask

  task automatic flush_model();
    q.delete();
    last_acc = -100;
    last_res = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'($urandom), 1'b1);
      total++;
      if (obs_ready !== 1'b0 || obs_valid !== 1'b0 || obs_data !== 6'd0 ||
          obs_err !== 1'b0 || obs_pins !== 16'd0) begin
        bad++;
        $display("FAIL reset_outputs: ready=%b valid=%b data=%0d err=%b pins=%h, want all 0",
                 obs_ready, obs_valid, obs_data, obs_err, obs_pins);
      end
    end
    rst = 1'b0;
    flush_model();
    cycle(1'b0, 16'd0, 1'b1);
    total++;
    if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: ready=%b valid=%b, want 1 0", obs_ready, obs_valid);
    end
  endtask

  task automatic test_single_add();
    logic [15:0] d;
    d = mk(5, 3, 2, 1, 0, 0, 0, 0, 0, 0);
    cycle(1'b1, d, 1'b1);
    total++;
    if (did_acc !== 1'b1) begin bad++; $display("FAIL add_accept: accepted=%b want 1", did_acc); end
    cycle(1'b0, 16'd0, 1'b1);
    total++;
    if (obs_pins !== d) begin bad++; $display("FAIL add_pins: got %h want %h", obs_pins, d); end
    cycle(1'b0, 16'd0, 1'b1);
    total++;
    if (obs_pins !== 16'd0) begin bad++; $display("FAIL add_idle_pins: got %h want 0", obs_pins); end
    cycle(1'b0, 16'd0, 1'b1);
    total++;
    if (obs_valid !== 1'b0) begin bad++; $display("FAIL add_early: valid=%b want 0", obs_valid); end
    cycle(1'b0, 16'd0, 1'b1);
    total++;
    if (obs_valid !== 1'b1 || obs_data !== 6'd9 || obs_err !== 1'b0) begin
      bad++;
      $display("FAIL add_rsp: valid=%b data=%0d err=%b, want 1 9 0", obs_valid, obs_data, obs_err);
    end
    cycle(1'b0, 16'd0, 1'b1);
    total++;
    if (obs_valid !== 1'b0) begin bad++; $display("FAIL add_popped: valid=%b want 0", obs_valid); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] got [2];
    int at [2];
    int n;
    n = 0;
    cycle(1'b1, mk(7, 7, 3, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    cycle(1'b1, mk(0, 0, 4, 0, 1, 1, 0, 0, 0, 0), 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 16'd0, 1'b1);
      if (did_pop && n < 2) begin
        got[n] = obs_data;
        at[n]  = i;
        n++;
        total++;
        if (obs_data !== exp_data || obs_err !== 1'b0) begin
          bad++;
          $display("FAIL chain_model: got %0d/%b want %0d/0", obs_data, obs_err, exp_data);
        end
      end
    end
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL chain_count: got %0d responses want 2", n);
    end else begin
      total++;
      if (got[0] !== 6'd49 || got[1] !== 6'd35 || at[1] != at[0] + 1) begin
        bad++;
        $display("FAIL chain_values: got %0d,%0d gap %0d want 49,35 gap 1",
                 got[0], got[1], at[1] - at[0]);
      end
    end
  endtask

  task automatic test_errors();
    logic [15:0] cmds [6];
    logic [5:0]  want_d [6];
    logic        want_e [6];
    logic        got;
    cmds[0] = mk(5, 2, 6, 0, 0, 0, 0, 0, 0, 0); want_d[0] = 6'd0; want_e[0] = 1'b1;
    cmds[1] = mk(3, 2, 2, 0, 0, 0, 1, 0, 0, 0); want_d[1] = 6'd0; want_e[1] = 1'b1;
    cmds[2] = mk(2, 7, 0, 0, 0, 0, 0, 1, 0, 0); want_d[2] = 6'd1; want_e[2] = 1'b0;
    cmds[3] = mk(6, 1, 7, 0, 0, 0, 0, 0, 1, 0); want_d[3] = 6'd6; want_e[3] = 1'b1;
    cmds[4] = mk(7, 1, 1, 0, 0, 0, 1, 0, 0, 0); want_d[4] = 6'd1; want_e[4] = 1'b0;
    cmds[5] = mk(2, 5, 2, 1, 0, 0, 0, 0, 0, 1); want_d[5] = 6'd5; want_e[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, cmds[i], 1'b1);
      got = 1'b0;
      for (int w = 0; w < 8 && !got; w++) begin
        cycle(1'b0, 16'd0, 1'b1);
        if (did_pop) begin
          got = 1'b1;
          total++;
          if (obs_data !== want_d[i] || obs_err !== want_e[i]) begin
            bad++;
            $display("FAIL err_case%0d: got %0d/%b want %0d/%b",
                     i, obs_data, obs_err, want_d[i], want_e[i]);
          end
        end
      end
      if (!got) begin
        total++; bad++;
        $display("FAIL err_case%0d_timeout: no response in 8 cycles", i);
      end
    end
  endtask

  task automatic test_backpressure();
    int idx, n;
    idx = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, mk(idx, 0, 2, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      if (did_acc) idx++;
      total++;
      if (obs_ready !== exp_ready) begin
        bad++;
        $display("FAIL bp_ready: cyc %0d got %b want %b", cyc, obs_ready, exp_ready);
      end
    end
    cycle(1'b0, 16'd0, 1'b0);
    total++;
    if (idx != DEPTH || obs_ready !== 1'b0 || obs_valid !== 1'b1 || obs_data !== 6'd0) begin
      bad++;
      $display("FAIL bp_full: accepted=%0d ready=%b valid=%b data=%0d want 4 0 1 0",
               idx, obs_ready, obs_valid, obs_data);
    end
    for (int i = 0; i < 30 && n < 6; i++) begin
      cycle(idx < 6, mk(idx, 0, 2, 0, 0, 0, 0, 0, 0, 0), 1'b1);
      if (did_acc) idx++;
      total++;
      if (obs_ready !== exp_ready) begin
        bad++;
        $display("FAIL bp_credit: cyc %0d ready got %b want %b", cyc, obs_ready, exp_ready);
      end
      if (did_pop) begin
        total++;
        if (obs_data !== 6'(n) || obs_err !== 1'b0) begin
          bad++;
          $display("FAIL bp_order: got %0d/%b want %0d/0", obs_data, obs_err, n);
        end
        n++;
      end
    end
    total++;
    if (n != 6 || idx != 6) begin
      bad++;
      $display("FAIL bp_drain: returned=%0d accepted=%0d want 6 6", n, idx);
    end
  endtask

  task automatic test_reset_mid();
    logic got;
    cycle(1'b1, mk(1, 2, 2, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    cycle(1'b1, mk(3, 3, 3, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    rst = 1'b1;
    flush_model();
    cycle(1'b1, mk(7, 7, 2, 1, 0, 0, 0, 0, 0, 0), 1'b1);
    total++;
    if (obs_pins !== 16'd0 || obs_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_clear: pins=%h valid=%b want 0 0", obs_pins, obs_valid);
    end
    rst = 1'b0;
    flush_model();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 16'd0, 1'b1);
      total++;
      if (obs_valid !== 1'b0) begin
        bad++;
        $display("FAIL midrst_ghost: cycle %0d valid=%b want 0", i, obs_valid);
      end
    end
    cycle(1'b1, mk(3, 4, 2, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    got = 1'b0;
    for (int w = 0; w < 8 && !got; w++) begin
      cycle(1'b0, 16'd0, 1'b1);
      if (did_pop) begin
        got = 1'b1;
        total++;
        if (obs_data !== 6'd7 || obs_err !== 1'b0) begin
          bad++;
          $display("FAIL midrst_fresh: got %0d/%b want 7/0", obs_data, obs_err);
        end
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL midrst_timeout: no response in 8 cycles");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, 16'($urandom), ($urandom % 4) != 0);
      total++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid) begin
        bad++;
        $display("FAIL rnd_hs: cyc %0d ready=%b/%b valid=%b/%b (got/want)",
                 cyc, obs_ready, exp_ready, obs_valid, exp_valid);
      end else if (exp_valid) begin
        total++;
        if (obs_data !== exp_data || obs_err !== exp_err) begin
          bad++;
          $display("FAIL rnd_data: cyc %0d got %0d/%b want %0d/%b",
                   cyc, obs_data, obs_err, exp_data, exp_err);
        end
      end
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 16'd0, 1'b1);
    total++;
    if (q.size() != 0 || obs_valid !== 1'b0) begin
      bad++;
      $display("FAIL rnd_drain: model left %0d, valid=%b want 0 0", q.size(), obs_valid);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b0;
    flush_model();
    @(negedge clk);
    test_reset();
    test_single_add();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alsu_cmd_ctrl.md
# alsu_cmd_ctrl

Command-side controller that drives the ALSU. It accepts packed operation commands over a valid/ready handshake and applies each to the ALSU input pins for exactly one cycle. It captures the ALSU result after the fixed pipeline latency and returns it, tagged with an error flag, over a second valid/ready handshake. Because the ALSU cannot stall, results are buffered in a credit-protected response FIFO.

## Interface
- ALSU_LAT, 2, clock edges from ALSU input pins to ALSU `out` update (input register + output register)
- DEPTH, 4, response FIFO depth and maximum outstanding commands (in flight + buffered); legal range ≥ 1, full throughput needs ≥ ALSU_LAT+2
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept this cycle
- cmd_data  in  16  [2:0] A, [5:3] B, [8:6] opcode, [9] cin, [10] serial_in, [11] direction, [12] red_op_A, [13] red_op_B, [14] bypass_A, [15] bypass_B
- A, B, opcode  out  3 each  registered drive to the ALSU
- cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B  out  1 each  registered drive to the ALSU
- alsu_out  in  6  ALSU `out`
- rsp_valid  out  1  response available (FIFO not empty)
- rsp_ready  in  1  consumer takes response
- rsp_data  out  6  captured ALSU result (FIFO head)
- rsp_err  out  1  command was invalid per ALSU rules

## Operation
- Accept: cmd_valid & cmd_ready at a rising edge. cmd_ready = (inflight + fifo_count) < DEPTH. It is combinational from registers only, with no path from cmd_valid.
- Drive: on an accepting edge, the ALSU outputs load the cmd_data fields. On any non-accepting edge they load the idle vector (all fields 0, i.e. AND of 0,0), which drives ALSU `out` to 0.
- Shift/rotate (opcode 100/101) act on the ALSU's previous result. A meaningful chain requires commands accepted on consecutive edges. After an idle cycle, the operand is 0.
- Error flag is computed from the command at accept: err = (opcode ∈ {110,111}) | (opcode ∉ {000,001} & (red_op_A | red_op_B)). It is independent of bypass. ALSU leds are not used; they toggle and cannot flag back-to-back invalids.
- In-flight tracking: a shift register (ALSU_LAT+1 stages) of {valid, err}. Stage 0 loads on accept, and the pipeline advances every cycle.
- Capture: when the last stage is valid, push {alsu_out, err} into the FIFO at that edge.
- FIFO: DEPTH entries, in-order. Pop on rsp_valid & rsp_ready. Simultaneous push and pop leaves the count unchanged. Overflow is impossible by credit. A pop while empty is a no-op.
- Counters: inflight goes 0..ALSU_LAT+1 and fifo_count goes 0..DEPTH. The sum never exceeds DEPTH.

## Timing
- Reset (async assert, sync release):
  - A, B, opcode and all 1-bit ALSU drives are 0.
  - In-flight pipeline and FIFO are cleared.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - cmd_ready=1 from the first cycle after release.
- Latency, for a command accepted at edge k:
  - ALSU pins carry the command during cycle k..k+1.
  - ALSU registers it at k+1; `out` updates at k+2.
  - Controller captures at edge k+3.
  - rsp_valid is high after k+3 if the FIFO was empty.
- Throughput: 1 command/cycle sustained while rsp_ready=1 and DEPTH ≥ ALSU_LAT+2.
- Backpressure: with rsp_ready=0, exactly DEPTH commands are accepted, then cmd_ready stays 0. Each pop frees one credit the next cycle.
- rsp_data/rsp_err are stable while rsp_valid & !rsp_ready.
- Reset mid-operation discards all in-flight and buffered results. No response emerges for commands accepted before reset.

## Test plan
- Reset: hold rst 3 cycles with cmd_valid=1 -> all outputs 0, no accept. After release, cmd_ready=1 and rsp_valid=0.
- Single add: A=5, B=3, opcode=010, cin=1 at edge k -> rsp_valid rises after edge k+3, rsp_data=9, rsp_err=0. ALSU pins return to idle after one cycle.
- Back-to-back chain: multiply A=7,B=7 then next cycle shift-left with direction=1, serial_in=1 -> responses 49 then 35, in consecutive cycles.
- Error and reduction cases:
  - opcode=110 -> data 0, err 1.
  - opcode=010 with red_op_A=1 -> data 0, err 1.
  - opcode=000, red_op_B=1, B=7 -> data 1, err 0.
  - bypass_A=1, A=6, opcode=111 -> data 6, err 1.
- Backpressure: rsp_ready=0, present 6 adds (A=i, B=0) -> only 4 accepted, cmd_ready=0. Raise rsp_ready -> outputs 0,1,2,3 in order, then 4,5 accepted and returned.
- Reset mid-flight: accept 2 commands, assert rst at the next edge -> no response ever appears, FIFO empty, and a fresh command afterward returns the correct result.
